// File: rtl/or_reduce_seq_if.sv
// Requester-side handshake bundle for the serial OR-reduction engine.
// Carries start/operand towards the engine and busy/done/result back.
interface or_reduce_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic             out;

  modport master (
    output start, in,
    input  busy, done, out
  );

  modport slave (
    input  start, in,
    output busy, done, out
  );
endinterface

// File: rtl/or_reduce_seq.sv
// Bit-serial OR-reduction: folds a WIDTH-bit word one bit per clock
// through a single 2-input Or gate, with a start/busy/done handshake.
module Or (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a | b;
endmodule

module or_reduce_seq #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 0
) (
  input  logic           clk,
  input  logic           reset,
  or_reduce_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             acc, acc_n;
  logic             res, res_n;
  logic             or_y;

  Or u_or (
    .a  (acc),
    .b  (sh[0]),
    .out(or_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      acc   <= 1'b0;
      res   <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
      res   <= res_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    acc_n   = acc;
    res_n   = res;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sh_n    = bus.in;
          acc_n   = 1'b0;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n = or_y;
        sh_n  = sh >> 1;
        cnt_n = cnt + CW'(1);
        // result latched only on the exiting edge
        if (cnt == LAST ||
            (EARLY_EXIT != 0 && or_y)) begin
          state_n = DONE;
          res_n   = or_y;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.out  = res;
endmodule

// File: tb/tb_or_reduce_seq.sv
// Directed bench for or_reduce_seq: one plain and one early-exit
// instance, checked with immediate assertions.
module tb_or_reduce_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   na = 0;
  int   nb = 0;

  always #5 clk = ~clk;

  or_reduce_seq_if #(.WIDTH(16)) ifa ();
  or_reduce_seq_if #(.WIDTH(16)) ifb ();

  or_reduce_seq #(.WIDTH(16), .EARLY_EXIT(0)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa)
  );

  or_reduce_seq #(.WIDTH(16), .EARLY_EXIT(1)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ifb)
  );

  always @(negedge clk) begin
    if (ifa.done) na++;
    if (ifb.done) nb++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ee, input logic s,
                       input logic [15:0] v);
    if (ee) begin
      ifb.start = s;
      ifb.in    = v;
    end else begin
      ifa.start = s;
      ifa.in    = v;
    end
  endtask

  function automatic logic busy_of(input bit ee);
    return ee ? ifb.busy : ifa.busy;
  endfunction

  function automatic logic done_of(input bit ee);
    return ee ? ifb.done : ifa.done;
  endfunction

  function automatic logic out_of(input bit ee);
    return ee ? ifb.out : ifa.out;
  endfunction

  // c counts cycles after the accepting edge, sampled #1 after each edge
  task automatic do_op(input bit ee, input logic [15:0] v,
                       input int poke_at, input int rst_at,
                       output int lat, output int bcyc,
                       output logic o, output logic pre);
    int   c;
    logic prev;
    lat  = -1;
    bcyc = 0;
    o    = 1'bx;
    pre  = 1'bx;
    @(negedge clk);
    drive(ee, 1'b1, v);
    @(posedge clk);
    #1;
    drive(ee, 1'b0, v);
    prev = out_of(ee);
    c = 0;
    while (c < 60) begin
      if (rst_at >= 0 && c == rst_at + 1) reset = 1'b0;
      if (busy_of(ee)) bcyc++;
      if (done_of(ee)) begin
        lat = c;
        o   = out_of(ee);
        pre = prev;
      end
      if (!busy_of(ee)) break;
      prev = out_of(ee);
      if (poke_at >= 0 && c == poke_at)
        drive(ee, 1'b1, 16'hFFFF);
      else if (poke_at >= 0 && c == poke_at + 1)
        drive(ee, 1'b0, 16'hFFFF);
      if (c == rst_at) reset = 1'b1;
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 60) chk("op_timeout", c, 0);
  endtask

  initial begin
    int lat, bc, d0, nd, mism, k, c;
    int t[3];
    logic o, pre;
    logic [15:0] v;

    drive(1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_out", ifa.out, 0);
    chk("rst_busy_b", ifb.busy, 0);
    reset = 1'b0;

    // 1: zero operand, full length
    d0 = na;
    do_op(0, 16'h0000, -1, -1, lat, bc, o, pre);
    chk("t1_lat", lat, 16);
    chk("t1_busy_cycles", bc, 17);
    chk("t1_out", o, 0);
    chk("t1_busy_after", ifa.busy, 0);
    chk("t1_pulses", na - d0, 1);

    // 2: MSB only, LSB only, then out falls at done
    do_op(0, 16'h8000, -1, -1, lat, bc, o, pre);
    chk("t2_msb_lat", lat, 16);
    chk("t2_msb_out", o, 1);
    do_op(0, 16'h0001, -1, -1, lat, bc, o, pre);
    chk("t2_lsb_lat", lat, 16);
    chk("t2_lsb_out", o, 1);
    do_op(0, 16'h0000, -1, -1, lat, bc, o, pre);
    chk("t2_zero_pre", pre, 1);
    chk("t2_zero_out", o, 0);
    chk("t2_zero_lat", lat, 16);

    // 3: early exit
    do_op(1, 16'h0004, -1, -1, lat, bc, o, pre);
    chk("t3_ee_lat", lat, 3);
    chk("t3_ee_out", o, 1);
    do_op(1, 16'h0000, -1, -1, lat, bc, o, pre);
    chk("t3_ee0_lat", lat, 16);
    chk("t3_ee0_out", o, 0);

    // 4: operand change and start pulse during RUN
    d0 = na;
    do_op(0, 16'h0000, 3, -1, lat, bc, o, pre);
    chk("t4_out", o, 0);
    chk("t4_lat", lat, 16);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_pulses", na - d0, 1);
    chk("t4_idle", ifa.busy, 0);

    // 5: reset mid-RUN aborts silently
    d0 = na;
    do_op(0, 16'hFFFF, -1, 5, lat, bc, o, pre);
    chk("t5_busy", ifa.busy, 0);
    chk("t5_done", ifa.done, 0);
    chk("t5_out", ifa.out, 0);
    chk("t5_nodone", lat, -1);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_pulses", na - d0, 0);
    do_op(0, 16'h0001, -1, -1, lat, bc, o, pre);
    chk("t5_after_lat", lat, 16);
    chk("t5_after_out", o, 1);

    // simultaneous reset and start
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b1, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("rst_start_busy", ifa.busy, 0);
    chk("rst_start_out", ifa.out, 0);
    drive(0, 1'b0, 16'h0000);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_idle", ifa.busy, 0);

    // 6: start held high, back-to-back
    @(negedge clk);
    drive(0, 1'b1, 16'h0010);
    c  = 0;
    nd = 0;
    while (c < 100 && nd < 3) begin
      @(posedge clk);
      #1;
      c++;
      if (ifa.done) begin
        t[nd] = c;
        chk("t6_out", ifa.out, 1);
        nd++;
      end
    end
    drive(0, 1'b0, 16'h0000);
    chk("t6_count", nd, 3);
    if (nd == 3) begin
      chk("t6_gap1", t[1] - t[0], 18);
      chk("t6_gap2", t[2] - t[1], 18);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle", ifa.busy, 0);

    // random operands against a bitwise OR reference
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      if (i == 0) v = 16'h0000;
      if (i == 1) v = 16'h8000;
      do_op(0, v, -1, -1, lat, bc, o, pre);
      if (o !== (|v)) mism++;
      chk("rand_or", o, |v);
    end
    for (int i = 0; i < 32; i++) begin
      v = 16'($urandom);
      if (i == 0) v = 16'h8000;
      k = 16;
      for (int b = 15; b >= 0; b--)
        if (v[b]) k = b + 1;
      do_op(1, v, -1, -1, lat, bc, o, pre);
      if (o !== (|v) || lat != k) mism++;
      chk("rand_ee_out", o, |v);
      chk("rand_ee_lat", lat, k);
    end
    if (mism == 0)
      $display("random sweep passed");
    else
      $display("random sweep: %0d bad", mism);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
